sev_seg_scan_decoder: RTL and testbench

- Receiving end of the multiplexed seven-segment health display.
- Samples the segment bus and one-hot digit select, and rejects patterns that are not stable long enough.
- Decodes each digit's segment pattern back to BCD and publishes a consistent per-digit value set once every required digit has been seen in a scan frame.
- Used as an on-board loopback monitor and as a self-checking scoreboard front end for the health display path.

---
 rtl/sev_seg_scan_decoder.sv | 127 ++++++++++++
 tb/tb_sev_seg_scan_decoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_decoder.sv
// sev_seg_scan_decoder: decodes a multiplexed seven-segment scan into per-digit BCD frames.
// Optional SEV_SEG_DP_CAPTURE_EN captures the decimal point per digit and lets it break stability.
module sev_seg_scan_decoder #(
   parameter int                DIGITS         = 5,
   parameter logic [DIGITS-1:0] DGT_MASK       = 5'b11111,
   parameter bit                SEG_ACTIVE_LOW = 1'b1,
   parameter bit                DGT_ACTIVE_LOW = 1'b1,
   parameter int                STABLE_CYC     = 4,
   parameter int                TIMEOUT_CYC    = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg_in,
   input  logic [DIGITS-1:0]     dgt_slct_in,
   output logic [4*DIGITS-1:0]   dgt_val,
   output logic [DIGITS-1:0]     dgt_err,
   output logic [DIGITS-1:0]     dp_val,
   output logic                  frm_done,
   output logic                  scan_lost
);
   logic [7:0]          r_seg_s1, r_seg_s2, r_prev_seg;
   logic [DIGITS-1:0]   r_sel_s1, r_sel_s2, r_prev_sel, r_seen, r_sh_err;
   logic [4*DIGITS-1:0] r_sh_val;
   logic [7:0]          r_cnt;
   logic [19:0]         r_idle;
   logic [7:0]          w_seg, w_seg_c, w_cnt_nxt;
   logic [DIGITS-1:0]   w_sel;
   logic [19:0]         w_idle_nxt;
   logic [3:0]          w_dec;
   logic                w_valid, w_same, w_acc, w_done, w_to;

   function automatic logic [3:0] f_dec(input logic [6:0] p);
      case (p)
         7'h3F: f_dec = 4'd0;
         7'h06: f_dec = 4'd1;
         7'h5B: f_dec = 4'd2;
         7'h4F: f_dec = 4'd3;
         7'h66: f_dec = 4'd4;
         7'h6D: f_dec = 4'd5;
         7'h7D: f_dec = 4'd6;
         7'h07: f_dec = 4'd7;
         7'h7F: f_dec = 4'd8;
         7'h6F: f_dec = 4'd9;
         default: f_dec = 4'hF;
      endcase
   endfunction

   assign w_seg = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
   assign w_sel = DGT_ACTIVE_LOW ? ~r_sel_s2 : r_sel_s2;
`ifdef SEV_SEG_DP_CAPTURE_EN
   assign w_seg_c = w_seg;
`else
   assign w_seg_c = w_seg & 8'h7F;
`endif
   assign w_dec      = f_dec(w_seg[6:0]);
   assign w_valid    = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
   assign w_same     = (w_sel == r_prev_sel) && (w_seg_c == r_prev_seg) && (r_cnt != 8'd0);
   assign w_cnt_nxt  = !w_valid ? 8'd0 : !w_same ? 8'd1 : (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
   // The guard stops a saturated counter (STABLE_CYC=255) from re-accepting every cycle
   assign w_acc      = w_valid && (w_cnt_nxt == 8'(STABLE_CYC)) && !(w_same && r_cnt == 8'(STABLE_CYC));
   assign w_done     = (r_seen & DGT_MASK) == DGT_MASK;
   assign w_idle_nxt = w_acc ? 20'd0 : w_valid ? r_idle : (r_idle == 20'(TIMEOUT_CYC)) ? r_idle : r_idle + 20'd1;
   assign w_to       = (w_idle_nxt == 20'(TIMEOUT_CYC)) && (r_idle != 20'(TIMEOUT_CYC));

`ifdef SEV_SEG_DP_CAPTURE_EN
   logic [DIGITS-1:0] r_sh_dp, r_dp_val;
   assign dp_val = r_dp_val;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_sh_dp  <= '0;
         r_dp_val <= '0;
      end else begin
         if (w_done) r_dp_val <= r_sh_dp;
         if (w_to) r_sh_dp <= '0;
         else if (w_acc) r_sh_dp <= (r_sh_dp & ~w_sel) | (w_seg[7] ? w_sel : '0);
      end
`else
   assign dp_val = '0;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_seg_s1   <= '0;
         r_seg_s2   <= '0;
         r_sel_s1   <= '0;
         r_sel_s2   <= '0;
         r_prev_seg <= '0;
         r_prev_sel <= '0;
         r_cnt      <= '0;
         r_idle     <= '0;
         r_seen     <= '0;
         r_sh_val   <= '0;
         r_sh_err   <= '0;
         dgt_val    <= '0;
         dgt_err    <= '0;
         frm_done   <= 1'b0;
         scan_lost  <= 1'b0;
      end else begin
         r_seg_s1   <= seg_in;
         r_seg_s2   <= r_seg_s1;
         r_sel_s1   <= dgt_slct_in;
         r_sel_s2   <= r_sel_s1;
         r_prev_seg <= w_seg_c;
         r_prev_sel <= w_sel;
         r_cnt      <= w_cnt_nxt;
         r_idle     <= w_idle_nxt;
         frm_done   <= w_done;
         if (w_done) begin
            dgt_val <= r_sh_val;
            dgt_err <= r_sh_err;
         end
         if (w_acc) scan_lost <= 1'b0;
         else if (w_to) scan_lost <= 1'b1;
         // Clearing before OR-ing makes a completion-cycle acceptance count toward the next frame
         r_seen <= w_to ? '0 : ((w_done ? '0 : r_seen) | (w_acc ? w_sel : '0));
         if (w_to) begin
            r_sh_val <= '0;
            r_sh_err <= '0;
         end else if (w_acc) begin
            for (int i = 0; i < DIGITS; i++)
               if (w_sel[i]) begin
                  r_sh_val[4*i +: 4] <= w_dec;
                  r_sh_err[i]        <= (w_dec == 4'hF);
               end
         end
      end
endmodule

// File: tb/tb_sev_seg_scan_decoder.sv
// tb_sev_seg_scan_decoder: directed self-checking bench for sev_seg_scan_decoder.
module tb_sev_seg_scan_decoder;
   localparam int TO = 300;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  seg_in = 8'hFF;
   logic [4:0]  dgt_slct_in = 5'b11111;
   logic [19:0] dgt_val;
   logic [4:0]  dgt_err, dp_val;
   logic        frm_done, scan_lost;
   int          ncmp = 0, nfail = 0, nframes = 0;

   sev_seg_scan_decoder #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dgt_slct_in(dgt_slct_in),
      .dgt_val(dgt_val), .dgt_err(dgt_err), .dp_val(dp_val),
      .frm_done(frm_done), .scan_lost(scan_lost)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (frm_done) nframes++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] lo(input int v);
      case (v)
         0: lo = ~8'h3F;
         1: lo = ~8'h06;
         2: lo = ~8'h5B;
         3: lo = ~8'h4F;
         4: lo = ~8'h66;
         5: lo = ~8'h6D;
         6: lo = ~8'h7D;
         7: lo = ~8'h07;
         8: lo = ~8'h7F;
         9: lo = ~8'h6F;
         default: lo = 8'hFF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: observed %0h required %0h", tag, o, e);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int d, input logic [7:0] p, input int n);
      dgt_slct_in = ~(5'b00001 << d);
      seg_in = p;
      step(n);
   endtask

   task automatic idle(input int n);
      dgt_slct_in = 5'b11111;
      seg_in = 8'hFF;
      step(n);
   endtask

   initial begin
      step(3);
      chk("rst_val", dgt_val, 0);
      chk("rst_err", dgt_err, 0);
      chk("rst_dp", dp_val, 0);
      chk("rst_done", frm_done, 0);
      chk("rst_lost", scan_lost, 0);
      rst = 1'b1;
      step(2);
      for (int i = 0; i < 5; i++) show(i, lo(i), 8);
      idle(6);
      chk("f1_frames", nframes, 1);
      chk("f1_val", dgt_val, 20'h43210);
      chk("f1_err", dgt_err, 0);
      chk("f1_dp", dp_val, 0);
      for (int i = 0; i < 5; i++) show(i, (i == 2) ? 8'hFF : lo(i), 8);
      idle(6);
      chk("blank_frames", nframes, 2);
      chk("blank_val", dgt_val, 20'h43F10);
      chk("blank_err", dgt_err, 5'b00100);
      for (int i = 0; i < 5; i++) show(i, lo(i + 5), 3);
      idle(6);
      chk("short_frames", nframes, 2);
      chk("short_val", dgt_val, 20'h43F10);
      for (int i = 0; i < 5; i++) show(i, lo(i + 5), 4);
      idle(6);
      chk("hold4_frames", nframes, 3);
      chk("hold4_val", dgt_val, 20'h98765);
      chk("hold4_err", dgt_err, 0);
      step(TO - 20);
      chk("to_early", scan_lost, 0);
      step(30);
      chk("to_lost", scan_lost, 1);
      chk("to_val", dgt_val, 20'h98765);
      chk("to_frames", nframes, 3);
      show(0, lo(1), 8);
      chk("to_recover", scan_lost, 0);
      show(1, lo(2), 8);
      show(2, lo(3), 8);
      rst = 1'b0;
      #1;
      chk("mid_rst_val", dgt_val, 0);
      chk("mid_rst_lost", scan_lost, 0);
      dgt_slct_in = 5'b11111;
      step(2);
      rst = 1'b1;
      step(2);
      show(3, lo(2), 8);
      show(4, lo(7), 8);
      idle(6);
      chk("partial_frames", nframes, 3);
      show(0, lo(1), 8);
      show(1, lo(8), 8);
      show(2, lo(6), 8);
      idle(6);
      chk("restart_frames", nframes, 4);
      chk("restart_val", dgt_val, 20'h72681);
      chk("restart_err", dgt_err, 0);
      for (int i = 0; i < 5; i++) show(i, (i == 1) ? (lo(1) & 8'h7F) : lo(i), 8);
      idle(6);
      chk("dp_frames", nframes, 5);
      chk("dp_val_digits", dgt_val, 20'h43210);
`ifdef SEV_SEG_DP_CAPTURE_EN
      chk("dp_capture", dp_val, 5'b00010);
`else
      chk("dp_capture", dp_val, 5'b00000);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
